// File: rtl/seq_lock_pkg.sv
// Shared constants, stored digit sequences and width helpers for the sequence-lock checker.
package seq_lock_pkg;

    localparam int unsigned DIG_W = 4;

    typedef enum logic [1:0] {
        ST_ENTRY  = 2'd0,
        ST_DONE   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] SEQ_TAB0 [16] = '{4'd2, 4'd7, 4'd1, 4'd8, 4'd2, 4'd8, 4'd1, 4'd8,
                                             4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    localparam logic [3:0] SEQ_TAB1 [16] = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9, 4'd2, 4'd6,
                                             4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};

    function automatic logic [3:0] seq_digit(input int unsigned id, input int unsigned idx);
        logic [3:0] d;
        d = 4'd0;
        if (idx < 16) begin
            d = (id == 1) ? SEQ_TAB1[idx[3:0]] : SEQ_TAB0[idx[3:0]];
        end
        return d;
    endfunction

    // Bits needed to hold 0..n.
    function automatic int unsigned idx_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n == 0) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_lock_checker_rom.sv
// Combinational two-port read of the selected stored sequence; out-of-range addresses read 0.
module seq_lock_checker_rom
    import seq_lock_pkg::*;
#(
    parameter int unsigned SEQ_LEN = 8,
    parameter int unsigned SEQ_ID  = 0,
    parameter int unsigned SW      = 4
) (
    input  logic [SW-1:0] addr_a,
    input  logic [SW-1:0] addr_b,
    output logic [3:0]    dig_a,
    output logic [3:0]    dig_b
);

    always_comb begin
        dig_a = '0;
        dig_b = '0;
        if (32'(addr_a) < SEQ_LEN) dig_a = seq_digit(SEQ_ID, 32'(addr_a));
        if (32'(addr_b) < SEQ_LEN) dig_b = seq_digit(SEQ_ID, 32'(addr_b));
    end

endmodule

// File: rtl/seq_lock_checker.sv
// Sequence-entry checker: compares strobed digits against a stored sequence, rolls back on error,
// counts misses with optional lockout and drives expected-digit / entry-log display halves.
module seq_lock_checker
    import seq_lock_pkg::*;
#(
    parameter int unsigned SEQ_LEN = 8,
    parameter int unsigned GROUP   = 4,
    parameter int unsigned NDIG    = 4,
    parameter int unsigned MAX_ERR = 3,
    parameter int unsigned SEQ_ID  = 0
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          CE,
    input  logic                          CLR,
    input  logic                          MODE,
    input  logic [3:0]                    DAT_I,
    output logic [8*NDIG-1:0]             DISP_SEQ,
    output logic [2*NDIG-1:0]             DISP_OFF,
    output logic [idx_w(SEQ_LEN)-1:0]     STEP,
    output logic [cnt_w(MAX_ERR)-1:0]     ERR_CNT,
    output logic                          MATCH_P,
    output logic                          MISS_P,
    output logic                          DONE,
    output logic                          LOCK
);

    localparam int unsigned SW = idx_w(SEQ_LEN);
    localparam int unsigned EW = cnt_w(MAX_ERR);
    localparam int unsigned LW = idx_w(NDIG);
    localparam int unsigned HW = NDIG * DIG_W;

    localparam logic [HW-1:0]   WSEQ_RST = HW'(seq_digit(SEQ_ID, 0));
    localparam logic [NDIG-1:0] WOFF_RST = ~(NDIG'(1));

    state_t          state_q, state_d;
    logic [SW-1:0]   step_q, step_d, chk_q, chk_d;
    logic [EW-1:0]   err_q, err_d;
    logic [HW-1:0]   wseq_q, wseq_d, lseq_q, lseq_d;
    logic [LW-1:0]   wlen_q, wlen_d;
    logic [NDIG-1:0] woff_q, woff_d, loff_q, loff_d;
    logic            match_q, match_d, miss_q, miss_d;

    logic [SW-1:0]   step_inc, tgt, addr_b;
    logic [3:0]      dig_cur, dig_b;
    logic            acted, is_match;

    assign step_inc = step_q + SW'(1);
    assign tgt      = MODE ? '0 : chk_q;
    assign is_match = (DAT_I == dig_cur);
    assign acted    = CE && !CLR && (state_q == ST_ENTRY);
    // Second port serves the next expected digit on a match, the rollback target otherwise.
    assign addr_b   = is_match ? step_inc : tgt;

    seq_lock_checker_rom #(
        .SEQ_LEN (SEQ_LEN),
        .SEQ_ID  (SEQ_ID),
        .SW      (SW)
    ) u_rom (
        .addr_a (step_q),
        .addr_b (addr_b),
        .dig_a  (dig_cur),
        .dig_b  (dig_b)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        chk_d   = chk_q;
        err_d   = err_q;
        wseq_d  = wseq_q;
        wlen_d  = wlen_q;
        woff_d  = woff_q;
        lseq_d  = lseq_q;
        loff_d  = loff_q;
        match_d = 1'b0;
        miss_d  = 1'b0;
        if (CLR) begin
            state_d = ST_ENTRY;
            step_d  = '0;
            chk_d   = '0;
            err_d   = '0;
            wseq_d  = WSEQ_RST;
            wlen_d  = LW'(1);
            woff_d  = WOFF_RST;
            lseq_d  = '0;
            loff_d  = '1;
        end else if (acted) begin
            lseq_d = (lseq_q << DIG_W) | HW'(DAT_I);
            loff_d = loff_q << 1;
            if (is_match) begin
                step_d  = step_inc;
                match_d = 1'b1;
                if (step_inc == SW'(SEQ_LEN)) begin
                    state_d = ST_DONE;
                    woff_d  = '1;
                end else if (wlen_q == LW'(NDIG)) begin
                    wseq_d = HW'(dig_b);
                    wlen_d = LW'(1);
                    woff_d = WOFF_RST;
                end else begin
                    wseq_d = (wseq_q << DIG_W) | HW'(dig_b);
                    wlen_d = wlen_q + LW'(1);
                    woff_d = woff_q << 1;
                end
                if ((step_inc % SW'(GROUP)) == '0) chk_d = step_inc;
            end else begin
                miss_d = 1'b1;
                step_d = tgt;
                if (MODE) chk_d = '0;
                wseq_d = HW'(dig_b);
                wlen_d = LW'(1);
                woff_d = WOFF_RST;
                if (err_q != '1) err_d = err_q + EW'(1);
                if ((MAX_ERR != 0) && (err_d == EW'(MAX_ERR))) state_d = ST_LOCKED;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= ST_ENTRY;
        else     state_q <= state_d;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            step_q  <= '0;
            chk_q   <= '0;
            err_q   <= '0;
            wseq_q  <= WSEQ_RST;
            wlen_q  <= LW'(1);
            woff_q  <= WOFF_RST;
            lseq_q  <= '0;
            loff_q  <= '1;
            match_q <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            step_q  <= step_d;
            chk_q   <= chk_d;
            err_q   <= err_d;
            wseq_q  <= wseq_d;
            wlen_q  <= wlen_d;
            woff_q  <= woff_d;
            lseq_q  <= lseq_d;
            loff_q  <= loff_d;
            match_q <= match_d;
            miss_q  <= miss_d;
        end
    end

    assign DISP_SEQ = {wseq_q, lseq_q};
    assign DISP_OFF = {woff_q, loff_q};
    assign STEP     = step_q;
    assign ERR_CNT  = err_q;
    assign MATCH_P  = match_q;
    assign MISS_P   = miss_q;
    assign DONE     = (state_q == ST_DONE);
    assign LOCK     = (state_q == ST_LOCKED);

endmodule
